// File: rtl/pc_gen_if.sv
// Fetch handshake between the PC generator (master) and the IFetcher (slave).
// fetch_kill flags that the fetch acked in the previous cycle was wrong-path.
interface pc_gen_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_ack;
    logic                  fetch_kill;

    modport master (
        output fetch_req,
        output fetch_addr,
        output fetch_kill,
        input  fetch_ack
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        input  fetch_kill,
        output fetch_ack
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: sequential increment, stall hold, redirect/trap vectoring,
// buffering of redirects that arrive while a fetch is outstanding.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no fetch outstanding; redirects/traps load pc directly
//   ST_REQ  | fetch_req high with fetch_addr=pc held until fetch_ack
module pc_gen #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           INST_BYTES   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = ADDR_WIDTH'(32'h100)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    input  logic                  trap_valid,
    pc_gen_if.master              fetch,
    output logic                  misalign_err
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(INST_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(INST_BYTES);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  pend_trap_q, pend_trap_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic                  kill_q, kill_d;
    logic                  misalign_q, misalign_d;

    logic [ADDR_WIDTH-1:0] tgt_aligned;
    logic                  tgt_misaligned;
    logic                  redirect_used;

    assign tgt_aligned    = redirect_target & ~LOW_MASK;
    assign tgt_misaligned = |(redirect_target & LOW_MASK);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_trap_d   = pend_trap_q;
        pend_addr_d   = pend_addr_q;
        kill_d        = 1'b0;
        redirect_used = 1'b0;

        if (state_q == ST_IDLE) begin
            if (trap_valid) begin
                pc_d = TRAP_VECTOR;
            end else if (redirect_valid) begin
                pc_d          = tgt_aligned;
                redirect_used = 1'b1;
            end
            if (!pc_stall) begin
                state_d = ST_REQ;
            end
        end else if (!fetch.fetch_ack) begin
            // A buffered trap must not be displaced by a later redirect.
            if (trap_valid) begin
                pend_valid_d = 1'b1;
                pend_trap_d  = 1'b1;
                pend_addr_d  = TRAP_VECTOR;
            end else if (redirect_valid && !pend_trap_q) begin
                pend_valid_d  = 1'b1;
                pend_addr_d   = tgt_aligned;
                redirect_used = 1'b1;
            end
        end else begin
            if (trap_valid) begin
                pc_d = TRAP_VECTOR;
            end else if (redirect_valid && !pend_trap_q) begin
                pc_d          = tgt_aligned;
                redirect_used = 1'b1;
            end else if (pend_valid_q) begin
                pc_d = pend_addr_q;
            end else begin
                pc_d = pc_q + PC_STEP;
            end
            kill_d       = trap_valid || redirect_valid || pend_valid_q;
            pend_valid_d = 1'b0;
            pend_trap_d  = 1'b0;
            state_d      = pc_stall ? ST_IDLE : ST_REQ;
        end

        misalign_d = redirect_used && tgt_misaligned;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_VECTOR;
            pend_valid_q <= 1'b0;
            pend_trap_q  <= 1'b0;
            pend_addr_q  <= '0;
            kill_q       <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_trap_q  <= pend_trap_d;
            pend_addr_q  <= pend_addr_d;
            kill_q       <= kill_d;
            misalign_q   <= misalign_d;
        end
    end

    assign fetch.fetch_req  = (state_q == ST_REQ);
    assign fetch.fetch_addr = pc_q;
    assign fetch.fetch_kill = kill_q;
    assign misalign_err     = misalign_q;
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus random stimulus, all checked against a
// rule-level reference model of the fetch/redirect behaviour.
module tb_pc_gen;
    localparam int unsigned AW = 32;
    localparam int unsigned IB = 4;
    localparam logic [31:0] RV = 32'h0000_1000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic        misalign_err;

    pc_gen_if #(.ADDR_WIDTH(AW)) fif ();

    pc_gen #(
        .ADDR_WIDTH  (AW),
        .INST_BYTES  (IB),
        .RESET_VECTOR(RV),
        .TRAP_VECTOR (TV)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_stall       (pc_stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .trap_valid     (trap_valid),
        .fetch          (fif.master),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: what the outputs must show after the next edge
    logic [31:0] m_pc;
    bit          m_req;
    bit          m_kill;
    bit          m_mis;
    bit          m_pend;
    bit          m_pend_trap;
    logic [31:0] m_pend_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & ~32'(IB - 1);
    endfunction

    task automatic model_reset();
        m_pc = RV; m_req = 0; m_kill = 0; m_mis = 0;
        m_pend = 0; m_pend_trap = 0; m_pend_addr = '0;
    endtask

    task automatic model_step(input bit st, input bit rv, input logic [31:0] tg,
                              input bit tr, input bit ak);
        bit mis = 0;
        bit kill = 0;
        if (!m_req) begin
            if (tr) m_pc = TV;
            else if (rv) begin m_pc = align(tg); mis = (tg % IB) != 0; end
            m_req = !st;
        end else if (!ak) begin
            if (tr) begin
                m_pend = 1; m_pend_trap = 1; m_pend_addr = TV;
            end else if (rv && !m_pend_trap) begin
                m_pend = 1; m_pend_addr = align(tg); mis = (tg % IB) != 0;
            end
        end else begin
            if (tr) m_pc = TV;
            else if (rv && !m_pend_trap) begin m_pc = align(tg); mis = (tg % IB) != 0; end
            else if (m_pend) m_pc = m_pend_addr;
            else m_pc = m_pc + IB;
            kill = tr || rv || m_pend;
            m_pend = 0; m_pend_trap = 0;
            m_req = !st;
        end
        m_kill = kill;
        m_mis  = mis;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".req"},  {31'b0, fif.fetch_req},  {31'b0, m_req});
        check({tag, ".addr"}, fif.fetch_addr,          m_pc);
        check({tag, ".kill"}, {31'b0, fif.fetch_kill}, {31'b0, m_kill});
        check({tag, ".mis"},  {31'b0, misalign_err},   {31'b0, m_mis});
    endtask

    // one clock: drive inputs just after an edge, step the model, compare after the next edge
    task automatic cyc(input string tag, input bit st, input bit rv, input logic [31:0] tg,
                       input bit tr, input bit ak);
        pc_stall = st; redirect_valid = rv; redirect_target = tg;
        trap_valid = tr; fif.fetch_ack = ak;
        model_step(st, rv, tg, tr, ak);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // reset asserted between edges must act immediately
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pc_stall = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
        trap_valid = 1'b0; fif.fetch_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // T1: reset mid-REQ with a pending redirect
        cyc("t1_go", 0, 0, 0, 0, 0);
        cyc("t1_pend", 0, 1, 32'h500, 0, 0);
        async_reset("t1_rst");
        cyc("t1_req", 0, 0, 0, 0, 0);
        check("t1_addr", fif.fetch_addr, RV);
        cyc("t1_ack", 0, 0, 0, 0, 1);
        check("t1_seq", fif.fetch_addr, RV + 32'd4);
        check("t1_nokill", {31'b0, fif.fetch_kill}, 32'd0);
        cyc("t1_idle", 1, 0, 0, 0, 1);

        // T2: sequential across the address wrap
        cyc("t2_jump", 0, 1, 32'hFFFF_FFF8, 0, 0);
        check("t2_a0", fif.fetch_addr, 32'hFFFF_FFF8);
        cyc("t2_s1", 0, 0, 0, 0, 1);
        check("t2_a1", fif.fetch_addr, 32'hFFFF_FFFC);
        cyc("t2_s2", 0, 0, 0, 0, 1);
        check("t2_a2", fif.fetch_addr, 32'h0000_0000);
        cyc("t2_s3", 1, 0, 0, 0, 1);
        check("t2_a3", fif.fetch_addr, 32'h0000_0004);
        check("t2_idle", {31'b0, fif.fetch_req}, 32'd0);

        // T3: handshake hold under stall
        cyc("t3_go", 0, 1, 32'h40, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc("t3_hold", 1, 0, 0, 0, 0);
            check("t3_addr", fif.fetch_addr, 32'h40);
            check("t3_req", {31'b0, fif.fetch_req}, 32'd1);
        end
        cyc("t3_ack", 1, 0, 0, 0, 1);
        check("t3_drop", {31'b0, fif.fetch_req}, 32'd0);

        // T4: buffered redirect
        cyc("t4_go", 0, 1, 32'h40, 0, 0);
        cyc("t4_redir", 0, 1, 32'h200, 0, 0);
        cyc("t4_w1", 0, 0, 0, 0, 0);
        check("t4_held", fif.fetch_addr, 32'h40);
        cyc("t4_w2", 0, 0, 0, 0, 0);
        cyc("t4_ack", 0, 0, 0, 0, 1);
        check("t4_addr", fif.fetch_addr, 32'h200);
        check("t4_kill", {31'b0, fif.fetch_kill}, 32'd1);
        cyc("t4_after", 0, 0, 0, 0, 0);
        check("t4_pulse", {31'b0, fif.fetch_kill}, 32'd0);

        // T5: pending trap beats redirect on the ack cycle; trap beats redirect in IDLE
        cyc("t5_trap", 0, 0, 0, 1, 0);
        cyc("t5_ack", 0, 1, 32'h300, 0, 1);
        check("t5_addr", fif.fetch_addr, TV);
        check("t5_kill", {31'b0, fif.fetch_kill}, 32'd1);
        cyc("t5_idle", 1, 0, 0, 0, 1);
        cyc("t5_move", 1, 1, 32'h80, 0, 0);
        cyc("t5_both", 1, 1, 32'h300, 1, 0);
        check("t5_idle_addr", fif.fetch_addr, TV);

        // T6: misaligned redirect in IDLE
        cyc("t6_mis", 1, 1, 32'h203, 0, 0);
        check("t6_addr", fif.fetch_addr, 32'h200);
        check("t6_err", {31'b0, misalign_err}, 32'd1);
        cyc("t6_after", 1, 0, 0, 0, 0);
        check("t6_pulse", {31'b0, misalign_err}, 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          st, rv, tr, ak;
            logic [31:0] tg;
            st = ($urandom_range(0, 9) < 3);
            rv = ($urandom_range(0, 9) < 2);
            tr = ($urandom_range(0, 99) < 6);
            ak = $urandom_range(0, 1) == 1;
            tg = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 3) != 0) tg = tg & ~32'h3;
            if ($urandom_range(0, 15) == 0) tg = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            if ($urandom_range(0, 399) == 0) async_reset("rnd_rst");
            else cyc("rnd", st, rv, tg, tr, ak);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
